// File: rtl/text_write_sequencer.sv
// Character plane write sequencer: buffers feeder bytes, tracks the cursor,
// decodes control codes and runs full-screen / single-row blank sequences.
module text_write_sequencer #(
  parameter int unsigned ROWS       = 16,
  parameter int unsigned COLS       = 64,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  BLANK_CHAR = 8'h20
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [7:0]                cin,
  input  logic                      cin_valid,
  output logic                      cin_ready,
  output logic [7:0]                plane_char,
  output logic [$clog2(ROWS)-1:0]   plane_row,
  output logic [$clog2(COLS)-1:0]   plane_col,
  output logic                      plane_we,
  output logic [$clog2(ROWS)-1:0]   cursor_row,
  output logic [$clog2(COLS)-1:0]   cursor_col,
  output logic                      busy
);

  localparam int unsigned RW   = $clog2(ROWS);
  localparam int unsigned CW   = $clog2(COLS);
  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNTW = AW + 1;
  localparam int unsigned CLRW = RW + CW;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    FULL_CLEAR = 2'd1,
    ROW_CLEAR  = 2'd2
  } state_t;

  state_t state;

  // Input byte FIFO
  logic [7:0]      fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CNTW-1:0] count;
  logic            push;
  logic            pop;
  logic [7:0]      head;

  assign cin_ready = (count != CNTW'(FIFO_DEPTH));
  assign push      = cin_valid && cin_ready;
  // The first IDLE cycle after a clear still shows busy; popping waits for it to drop.
  assign pop       = (state == IDLE) && !busy && (count != '0);
  assign head      = fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= cin;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

  // Byte classification and cursor arithmetic
  logic          is_print;
  logic          is_newline;
  logic          is_backspace;
  logic          is_formfeed;
  logic [RW-1:0] row_inc;
  logic [RW-1:0] bs_row;
  logic [CW-1:0] bs_col;
  logic          at_last_col;

  assign is_print     = (head >= 8'h20) && (head <= 8'h7E);
  assign is_newline   = (head == 8'h0A) || (head == 8'h0D);
  assign is_backspace = (head == 8'h08);
  assign is_formfeed  = (head == 8'h0C);
  assign at_last_col  = (cursor_col == CW'(COLS - 1));
  assign row_inc      = (cursor_row == RW'(ROWS - 1)) ? '0 : cursor_row + RW'(1);

  always_comb begin
    bs_row = cursor_row;
    bs_col = cursor_col;
    if (cursor_col != '0) begin
      bs_col = cursor_col - CW'(1);
    end else if (cursor_row != '0) begin
      bs_row = cursor_row - RW'(1);
      bs_col = CW'(COLS - 1);
    end
  end

  // Sequencer FSM with registered plane, cursor and busy outputs
  logic [CLRW-1:0] clr_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FULL_CLEAR;
      clr_cnt    <= '0;
      plane_char <= '0;
      plane_row  <= '0;
      plane_col  <= '0;
      plane_we   <= 1'b0;
      cursor_row <= '0;
      cursor_col <= '0;
      busy       <= 1'b0;
    end else begin
      plane_we <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (pop) begin
            if (is_print) begin
              plane_we   <= 1'b1;
              plane_char <= head;
              plane_row  <= cursor_row;
              plane_col  <= cursor_col;
              if (at_last_col) begin
                cursor_col <= '0;
                cursor_row <= row_inc;
                clr_cnt    <= '0;
                state      <= ROW_CLEAR;
              end else begin
                cursor_col <= cursor_col + CW'(1);
              end
            end else if (is_newline) begin
              cursor_col <= '0;
              cursor_row <= row_inc;
              clr_cnt    <= '0;
              state      <= ROW_CLEAR;
            end else if (is_backspace) begin
              plane_we   <= 1'b1;
              plane_char <= BLANK_CHAR;
              plane_row  <= bs_row;
              plane_col  <= bs_col;
              cursor_row <= bs_row;
              cursor_col <= bs_col;
            end else if (is_formfeed) begin
              clr_cnt <= '0;
              state   <= FULL_CLEAR;
            end
          end
        end

        FULL_CLEAR: begin
          busy       <= 1'b1;
          plane_we   <= 1'b1;
          plane_char <= BLANK_CHAR;
          plane_row  <= clr_cnt[CLRW-1:CW];
          plane_col  <= clr_cnt[CW-1:0];
          if (clr_cnt == CLRW'(ROWS * COLS - 1)) begin
            cursor_row <= '0;
            cursor_col <= '0;
            state      <= IDLE;
          end else begin
            clr_cnt <= clr_cnt + CLRW'(1);
          end
        end

        ROW_CLEAR: begin
          busy       <= 1'b1;
          plane_we   <= 1'b1;
          plane_char <= BLANK_CHAR;
          plane_row  <= cursor_row;
          plane_col  <= clr_cnt[CW-1:0];
          if (clr_cnt[CW-1:0] == CW'(COLS - 1)) begin
            state <= IDLE;
          end else begin
            clr_cnt <= clr_cnt + CLRW'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_text_write_sequencer.sv
// Directed bench for text_write_sequencer: decode table plus clear, fill,
// wrap, FIFO-full and reset-abort sequences.
module tb_text_write_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] cin = 8'h00;
  logic       cin_valid = 1'b0;
  logic       cin_ready;
  logic [7:0] plane_char;
  logic [3:0] plane_row;
  logic [5:0] plane_col;
  logic       plane_we;
  logic [3:0] cursor_row;
  logic [5:0] cursor_col;
  logic       busy;

  int checks = 0;
  int errors = 0;

  text_write_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .cin        (cin),
    .cin_valid  (cin_valid),
    .cin_ready  (cin_ready),
    .plane_char (plane_char),
    .plane_row  (plane_row),
    .plane_col  (plane_col),
    .plane_we   (plane_we),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    logic       we;
    logic [7:0] ch;
    logic [3:0] r;
    logic [5:0] c;
    logic [3:0] cr;
    logic [5:0] cc;
    logic       rc;
  } vec_t;

  vec_t vecs [14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expect a blank sequence starting at the next edge, then busy and we low.
  task automatic check_clear(input bit full, input logic [3:0] row);
    int n;
    logic [3:0] er;
    logic [5:0] ec;
    n = full ? 1024 : 64;
    for (int i = 0; i < n; i++) begin
      tick();
      er = full ? 4'(i / 64) : row;
      ec = 6'(i % 64);
      chk(full ? "full_clear_write" : "row_clear_write",
          32'({plane_we, busy, cin_ready, plane_char, plane_row, plane_col}),
          32'({1'b1, 1'b1, 1'b1, 8'h20, er, ec}));
    end
    tick();
    chk("clear_end_we_busy", 32'({plane_we, busy}), 32'(2'b00));
  endtask

  task automatic send_byte(input logic [7:0] b, input logic we, input logic [7:0] ch,
                           input logic [3:0] r, input logic [5:0] c,
                           input logic [3:0] cr, input logic [5:0] cc, input logic rc);
    cin       = b;
    cin_valid = 1'b1;
    tick();
    cin_valid = 1'b0;
    tick();
    chk($sformatf("byte_%02h_we", b), 32'(plane_we), 32'(we));
    if (we) begin
      chk($sformatf("byte_%02h_write", b), 32'({plane_char, plane_row, plane_col}),
          32'({ch, r, c}));
    end
    chk($sformatf("byte_%02h_cursor", b), 32'({cursor_row, cursor_col}), 32'({cr, cc}));
    if (rc) begin
      check_clear(1'b0, cr);
    end
  endtask

  logic [7:0] got_ch  [5];
  logic [9:0] got_pos [5];

  initial begin
    int  nw;
    logic rdy;

    vecs[0]  = '{8'h41, 1'b1, 8'h41, 4'd0, 6'd0,  4'd0, 6'd1,  1'b0};
    vecs[1]  = '{8'h42, 1'b1, 8'h42, 4'd0, 6'd1,  4'd0, 6'd2,  1'b0};
    vecs[2]  = '{8'h07, 1'b0, 8'h00, 4'd0, 6'd0,  4'd0, 6'd2,  1'b0};
    vecs[3]  = '{8'h08, 1'b1, 8'h20, 4'd0, 6'd1,  4'd0, 6'd1,  1'b0};
    vecs[4]  = '{8'h08, 1'b1, 8'h20, 4'd0, 6'd0,  4'd0, 6'd0,  1'b0};
    vecs[5]  = '{8'h08, 1'b1, 8'h20, 4'd0, 6'd0,  4'd0, 6'd0,  1'b0};
    vecs[6]  = '{8'h7E, 1'b1, 8'h7E, 4'd0, 6'd0,  4'd0, 6'd1,  1'b0};
    vecs[7]  = '{8'h0D, 1'b0, 8'h00, 4'd0, 6'd0,  4'd1, 6'd0,  1'b1};
    vecs[8]  = '{8'h08, 1'b1, 8'h20, 4'd0, 6'd63, 4'd0, 6'd63, 1'b0};
    vecs[9]  = '{8'h21, 1'b1, 8'h21, 4'd0, 6'd63, 4'd1, 6'd0,  1'b1};
    vecs[10] = '{8'h1F, 1'b0, 8'h00, 4'd0, 6'd0,  4'd1, 6'd0,  1'b0};
    vecs[11] = '{8'h7F, 1'b0, 8'h00, 4'd0, 6'd0,  4'd1, 6'd0,  1'b0};
    vecs[12] = '{8'h0A, 1'b0, 8'h00, 4'd0, 6'd0,  4'd2, 6'd0,  1'b1};
    vecs[13] = '{8'h08, 1'b1, 8'h20, 4'd1, 6'd63, 4'd1, 6'd63, 1'b0};

    // Reset state, then the power-on full clear
    tick();
    tick();
    chk("reset_state",
        32'({plane_we, busy, cin_ready, plane_char, plane_row, plane_col, cursor_row, cursor_col}),
        32'({1'b0, 1'b0, 1'b1, 8'h00, 4'd0, 6'd0, 4'd0, 6'd0}));
    reset = 1'b0;
    check_clear(1'b1, 4'd0);
    chk("post_clear_cursor", 32'({cursor_row, cursor_col}), 32'(10'd0));

    // Decode table
    for (int i = 0; i < 14; i++) begin
      send_byte(vecs[i].b, vecs[i].we, vecs[i].ch, vecs[i].r, vecs[i].c,
                vecs[i].cr, vecs[i].cc, vecs[i].rc);
    end

    // Form feed, then fill row 0 back-to-back and wrap into a row-1 clear
    send_byte(8'h0C, 1'b0, 8'h00, 4'd0, 6'd0, 4'd1, 6'd63, 1'b0);
    check_clear(1'b1, 4'd0);
    chk("formfeed_cursor", 32'({cursor_row, cursor_col}), 32'(10'd0));
    for (int k = 0; k <= 64; k++) begin
      if (k < 64) begin
        cin       = 8'(8'h30 + k);
        cin_valid = 1'b1;
      end else begin
        cin_valid = 1'b0;
      end
      tick();
      if (k >= 1) begin
        chk("fill_write", 32'({plane_we, plane_char, plane_row, plane_col}),
            32'({1'b1, 8'(8'h30 + k - 1), 4'd0, 6'(k - 1)}));
      end
    end
    chk("fill_cursor", 32'({cursor_row, cursor_col}), 32'({4'd1, 6'd0}));
    check_clear(1'b0, 4'd1);

    // Walk down to row 15, move to column 5, then newline wraps to row 0
    for (int r = 2; r < 16; r++) begin
      send_byte(8'h0A, 1'b0, 8'h00, 4'd0, 6'd0, 4'(r), 6'd0, 1'b1);
    end
    for (int i = 0; i < 5; i++) begin
      send_byte(8'(8'h61 + i), 1'b1, 8'(8'h61 + i), 4'd15, 6'(i), 4'd15, 6'(i + 1), 1'b0);
    end
    send_byte(8'h0A, 1'b0, 8'h00, 4'd0, 6'd0, 4'd0, 6'd0, 1'b1);

    // FIFO fills during a full clear; the fifth byte is held until space frees
    send_byte(8'h0C, 1'b0, 8'h00, 4'd0, 6'd0, 4'd0, 6'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cin       = 8'(8'h50 + i);
      cin_valid = 1'b1;
      tick();
      if (i < 4) begin
        chk("ready_after_push", 32'(cin_ready), 32'(i < 3));
      end else begin
        chk("ready_held_full", 32'({cin_ready, busy}), 32'(2'b01));
      end
    end
    nw = 0;
    for (int t = 0; t < 1500 && nw < 5; t++) begin
      rdy = cin_ready;
      tick();
      if (rdy) begin
        cin_valid = 1'b0;
      end
      if (plane_we && !busy) begin
        got_ch[nw]  = plane_char;
        got_pos[nw] = {plane_row, plane_col};
        nw++;
      end
    end
    cin_valid = 1'b0;
    chk("drain_count", 32'(nw), 32'(5));
    for (int i = 0; i < 5; i++) begin
      chk("drain_write", 32'({got_ch[i], got_pos[i]}), 32'({8'(8'h50 + i), 4'd0, 6'(i)}));
    end

    // Reset in the middle of a clear with bytes queued
    send_byte(8'h0C, 1'b0, 8'h00, 4'd0, 6'd0, 4'd0, 6'd5, 1'b0);
    for (int i = 0; i < 2; i++) begin
      cin       = 8'(8'h41 + i);
      cin_valid = 1'b1;
      tick();
    end
    cin_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
    end
    reset = 1'b1;
    tick();
    chk("midclear_reset_state",
        32'({plane_we, busy, cin_ready, plane_char, plane_row, plane_col, cursor_row, cursor_col}),
        32'({1'b0, 1'b0, 1'b1, 8'h00, 4'd0, 6'd0, 4'd0, 6'd0}));
    reset = 1'b0;
    check_clear(1'b1, 4'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("fifo_flushed_no_write", 32'(plane_we), 32'(0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/text_write_sequencer.md
Name: text_write_sequencer

Overview:
- Owns the character plane write port (char/row/col/we) and sequences every write into the 16x64 text plane.
- Buffers incoming bytes from the character feeder in a small FIFO and tracks the cursor.
- Interprets control codes (newline, backspace, form feed) and runs multi-cycle clear sequences (full screen, single row) that block byte processing until finished.
- Sits between the input/feeder path and the character plane, upstream of the VGA pixel path.

Parameters:
- ROWS, 16, text rows; row index width 4.
- COLS, 64, text columns; column index width 6.
- FIFO_DEPTH, 4, input byte buffer entries (power of 2).
- BLANK_CHAR, 8'h20, code written by clears and backspace.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- cin  input  8  incoming character byte.
- cin_valid  input  1  cin valid this cycle.
- cin_ready  output  1  FIFO not full; byte accepted when cin_valid && cin_ready.
- plane_char  output  8  character to write.
- plane_row  output  4  write row.
- plane_col  output  6  write column.
- plane_we  output  1  one-cycle write strobe.
- cursor_row  output  4  current cursor row.
- cursor_col  output  6  current cursor column.
- busy  output  1  high while a clear sequence is running.

Behaviour:
- Reset: FIFO emptied; cursor = (0,0); plane_char/row/col = 0; plane_we = 0; busy = 0; state goes to FULL_CLEAR on the first cycle after reset deasserts. Reset during any operation aborts it, with the same effect.
- All plane_* outputs are registered. A byte popped in cycle N produces plane_we in cycle N+1.
- FIFO:
  - cin_ready = (count != FIFO_DEPTH), derived from count only.
  - When full, a push is refused even if a pop occurs in the same cycle.
  - Push and pop in the same cycle when not full leaves count unchanged.
  - Pushes are accepted in every state, including clears.
- States:
  - IDLE: if FIFO is non-empty, pop one byte per cycle and decode it (below); otherwise hold, plane_we = 0.
  - FULL_CLEAR: busy = 1. Write BLANK_CHAR at (r,c) from (0,0) to (ROWS-1, COLS-1), row-major, one write per cycle (1024 cycles). Then cursor = (0,0) and return to IDLE.
  - ROW_CLEAR: busy = 1. Write BLANK_CHAR to columns 0..COLS-1 of cursor_row (64 cycles), then return to IDLE.
- Decode in IDLE:
  - 0x20-0x7E printable:
    - Write the byte at the cursor, then col+1.
    - If col was COLS-1: col = 0 and row advances (newline rule), and the new row is cleared via ROW_CLEAR.
  - 0x0A or 0x0D newline:
    - col = 0; row = row+1, or 0 if row == ROWS-1 (wrap).
    - Enter ROW_CLEAR on the new row. No character write.
  - 0x08 backspace:
    - If col > 0: col-1.
    - Else if row > 0: row-1, col = COLS-1.
    - Else the cursor holds at (0,0).
    - Write BLANK_CHAR at the resulting cursor position.
  - 0x0C form feed: enter FULL_CLEAR.
  - Any other code: dropped; no write; cursor unchanged.
- Clear-sequence writes are back-to-back, with plane_we high every cycle of the sequence. busy falls in the cycle after the last clear write. Byte processing resumes the cycle after busy falls.
- cursor_row and cursor_col update in the same cycle as the plane_we associated with the byte. For newline, which has no write, they update the cycle after the pop.

Test Plan:
- Reset, then release -> 1024 consecutive plane_we pulses with char 0x20 covering (0,0)..(15,63) in order; busy high for exactly those cycles; cin_ready = 1 throughout; cursor (0,0) afterwards.
- After the clear, push 'A' (0x41), 'B' -> writes (0,0)=0x41, (0,1)=0x42 on consecutive cycles, one cycle after each pop; cursor ends at (0,2).
- Fill row 0 with 64 printable bytes -> 64th write at (0,63), then ROW_CLEAR of row 1 (64 blank writes); cursor (1,0).
- With cursor at (15,5), push 0x0A -> cursor (0,0); 64 blank writes to row 0; busy high for 64 cycles.
- Backspace at (2,0) -> blank written at (1,63), cursor (1,63). Backspace at (0,0) -> blank at (0,0), cursor unchanged. Push 0x07 -> no plane_we.
- Push 5 bytes back-to-back during FULL_CLEAR -> first 4 accepted, cin_ready = 0 while full, 5th held. Assert reset mid-clear -> FIFO empty, outputs zero, and the full clear restarts at (0,0).
